// File: rtl/band_meter_pkg.sv
// Shared types and helpers for the band_meter spectrum bar/peak generator.
package band_meter_pkg;

    localparam int NBANDS = 7;
    localparam int BAND_W = 8;

    typedef logic [BAND_W-1:0] band_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic band_t sat_sub8(input band_t a, input band_t b);
        if (a > b) begin
            return a - b;
        end else begin
            return 8'd0;
        end
    endfunction

    function automatic band_t max8(input band_t a, input band_t b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/band_meter_cell.sv
// Next-state function for one band: instant attack, linear decay, peak hold.
// Purely combinational; shared by all bands through the scan index mux.
module band_meter_cell
    import band_meter_pkg::*;
#(
    parameter int DECAY_STEP = 4,
    parameter int HOLD_TICKS = 30,
    parameter int HOLD_W     = 5
) (
    input  band_t             acc_i,
    input  band_t             level_i,
    input  band_t             peak_i,
    input  logic [HOLD_W-1:0] hold_i,
    output band_t             level_o,
    output band_t             peak_o,
    output logic [HOLD_W-1:0] hold_o
);

    localparam band_t             STEP      = band_t'(DECAY_STEP);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    band_t level_new_s;

    // Bar level: jump up to the accumulated maximum, otherwise fall by STEP but never below acc.
    always_comb begin
        level_new_s = level_i;
        if (acc_i >= level_i) begin
            level_new_s = acc_i;
        end else begin
            level_new_s = max8(sat_sub8(level_i, STEP), acc_i);
        end
    end

    // Peak marker follows the new level upward and only falls once its hold time has run out.
    always_comb begin
        level_o = level_new_s;
        peak_o  = peak_i;
        hold_o  = hold_i;
        if (level_new_s >= peak_i) begin
            peak_o = level_new_s;
            hold_o = HOLD_INIT;
        end else if (hold_i != '0) begin
            hold_o = hold_i - HOLD_ONE;
        end else begin
            peak_o = max8(peak_i - 8'd1, level_new_s);
        end
    end

endmodule

// File: rtl/band_meter.sv
// Display-rate bar level and peak-hold generator for seven spectrum bands.
// Optional clip indicator output is enabled with `define BAND_METER_CLIP_EN.
module band_meter
    import band_meter_pkg::*;
#(
    parameter int DECAY_DIV  = 800,
    parameter int DECAY_STEP = 4,
    parameter int HOLD_TICKS = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [7:0]  freq1,
    input  logic [7:0]  freq2,
    input  logic [7:0]  freq3,
    input  logic [7:0]  freq4,
    input  logic [7:0]  freq5,
    input  logic [7:0]  freq6,
    input  logic [7:0]  freq7,
    output logic [55:0] level_out,
    output logic [55:0] peak_out,
    output logic        frame_valid
`ifdef BAND_METER_CLIP_EN
    ,
    output logic [6:0]  clip_out
`endif
);

    localparam int                HOLD_W    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [15:0]       DIV_LAST  = 16'(DECAY_DIV - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NBANDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [NBANDS-1:0][BAND_W-1:0] freq_s;
    logic [NBANDS-1:0][BAND_W-1:0] acc_q, acc_d;
    logic [NBANDS-1:0][BAND_W-1:0] level_q, level_d;
    logic [NBANDS-1:0][BAND_W-1:0] peak_q, peak_d;
    logic [NBANDS-1:0][HOLD_W-1:0] hold_q, hold_d;

    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic              tick_pend_q, tick_pend_d;
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic              frame_valid_q, frame_valid_d;
    logic              tick_s;
    logic              take_s;
    logic              scan_s;
    band_t             cell_level_s;
    band_t             cell_peak_s;
    logic [HOLD_W-1:0] cell_hold_s;

    assign freq_s      = {freq7, freq6, freq5, freq4, freq3, freq2, freq1};
    assign level_out   = level_q;
    assign peak_out    = peak_q;
    assign frame_valid = frame_valid_q;

    // Divide the sample strobe down to the display tick rate.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_s     = 1'b0;
        if (ready) begin
            if (tick_cnt_q == DIV_LAST) begin
                tick_cnt_d = 16'd0;
                tick_s     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 16'd1;
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Scan sequencer; frame_valid is registered so it lands in the DONE cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_valid_d = 1'b0;
        take_s        = 1'b0;
        scan_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_pend_q) begin
                    take_s  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                scan_s = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d       = ST_DONE;
                    frame_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // A single pending flag: a fresh tick wins over the one being consumed, extra ticks are dropped.
    always_comb begin
        if (tick_s) begin
            tick_pend_d = 1'b1;
        end else if (take_s) begin
            tick_pend_d = 1'b0;
        end else begin
            tick_pend_d = tick_pend_q;
        end
    end

    band_meter_cell #(
        .DECAY_STEP (DECAY_STEP),
        .HOLD_TICKS (HOLD_TICKS),
        .HOLD_W     (HOLD_W)
    ) u_cell (
        .acc_i   (acc_q[idx_q]),
        .level_i (level_q[idx_q]),
        .peak_i  (peak_q[idx_q]),
        .hold_i  (hold_q[idx_q]),
        .level_o (cell_level_s),
        .peak_o  (cell_peak_s),
        .hold_o  (cell_hold_s)
    );

    // Max-accumulate every sample; the scanned band takes the cell result and restarts its
    // accumulator, keeping a coincident sample rather than losing it to the clear.
    always_comb begin
        acc_d   = acc_q;
        level_d = level_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        for (int k = 0; k < NBANDS; k++) begin
            if (ready) begin
                acc_d[k] = max8(acc_q[k], freq_s[k]);
            end else begin
                acc_d[k] = acc_q[k];
            end
            if (scan_s && (idx_q == 3'(k))) begin
                level_d[k] = cell_level_s;
                peak_d[k]  = cell_peak_s;
                hold_d[k]  = cell_hold_s;
                if (ready) begin
                    acc_d[k] = freq_s[k];
                end else begin
                    acc_d[k] = 8'd0;
                end
            end else begin
                level_d[k] = level_q[k];
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            level_q       <= '0;
            peak_q        <= '0;
            hold_q        <= '0;
            tick_cnt_q    <= 16'd0;
            tick_pend_q   <= 1'b0;
            state_q       <= ST_IDLE;
            idx_q         <= 3'd0;
            frame_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            level_q       <= level_d;
            peak_q        <= peak_d;
            hold_q        <= hold_d;
            tick_cnt_q    <= tick_cnt_d;
            tick_pend_q   <= tick_pend_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_valid_q <= frame_valid_d;
        end
    end

`ifdef BAND_METER_CLIP_EN
    logic [NBANDS-1:0][HOLD_W-1:0] clip_cnt_q, clip_cnt_d;
    logic [NBANDS-1:0]             clip_q, clip_d;

    assign clip_out = clip_q;

    // Clip flag stays up for HOLD_TICKS visits after the last full-scale visit.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        clip_d     = clip_q;
        for (int k = 0; k < NBANDS; k++) begin
            if (scan_s && (idx_q == 3'(k))) begin
                if (acc_q[k] == 8'hFF) begin
                    clip_cnt_d[k] = HOLD_INIT;
                    clip_d[k]     = 1'b1;
                end else if (clip_cnt_q[k] != '0) begin
                    clip_cnt_d[k] = clip_cnt_q[k] - HOLD_ONE;
                    clip_d[k]     = 1'b1;
                end else begin
                    clip_d[k]     = 1'b0;
                end
            end else begin
                clip_d[k] = clip_q[k];
            end
        end
    end

    // Clip registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clip_cnt_q <= '0;
            clip_q     <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
            clip_q     <= clip_d;
        end
    end
`endif

endmodule
